// File: rtl/morse_tx_sequencer_pkg.sv
// rtl/morse_tx_sequencer_pkg.sv - shared widths, state encoding and element selector
package morse_tx_sequencer_pkg;

    localparam int CHAR_W   = 6;
    localparam int PAT_W    = 5;
    localparam int MAX_CHAR = 35;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CAPT = 3'd2,
        ST_SCAN = 3'd3,
        ST_MARK = 3'd4,
        ST_GAP  = 3'd5,
        ST_CGAP = 3'd6,
        ST_DONE = 3'd7
    } state_e;

    // Highest element position at or below idx whose display bit is set.
    function automatic logic [2:0] highest_at_or_below(input logic [PAT_W-1:0] disp,
                                                       input logic [2:0] idx);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < PAT_W; i++) begin
            if (disp[i] && (3'(i) <= idx)) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/morse_tx_sequencer_unit_timer.sv
// rtl/morse_tx_sequencer_unit_timer.sv - loadable down-counter with terminal-count flag
module morse_unit_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/morse_tx_sequencer.sv
// rtl/morse_tx_sequencer.sv - keys one character onto a Morse line via the codifier handshake
module morse_tx_sequencer
    import morse_tx_sequencer_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int DOT_UNITS   = 1,
    parameter int DASH_UNITS  = 3,
    parameter int GAP_UNITS   = 1,
    parameter int CHAR_UNITS  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] char_in,
    input  logic              char_valid,
    output logic              char_accept,
    output logic [CHAR_W-1:0] cod_num,
    output logic              cod_ready,
    input  logic [PAT_W-1:0]  cod_morse,
    input  logic [PAT_W-1:0]  cod_display,
    output logic              tone_out,
    output logic              ponto_out,
    output logic              traco_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int DOT_CYC  = DOT_UNITS * UNIT_CYCLES;
    localparam int DASH_CYC = DASH_UNITS * UNIT_CYCLES;
    localparam int GAP_CYC  = GAP_UNITS * UNIT_CYCLES;
    localparam int CHAR_CYC = CHAR_UNITS * UNIT_CYCLES;
    localparam int MAX_A    = (DOT_CYC > DASH_CYC) ? DOT_CYC : DASH_CYC;
    localparam int MAX_B    = (GAP_CYC > CHAR_CYC) ? GAP_CYC : CHAR_CYC;
    localparam int MAX_CYC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = $clog2(MAX_CYC + 1);

    state_e            state_q, state_d;
    logic [CHAR_W-1:0] cod_num_q, cod_num_d;
    logic [PAT_W-1:0]  morse_q, morse_d;
    logic [PAT_W-1:0]  disp_q, disp_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        cur_q, cur_d;
    logic              tone_q, tone_d;
    logic              ponto_q, ponto_d;
    logic              traco_q, traco_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cod_ready_q, cod_ready_d;

    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_tc;
    logic [2:0]        sel;
    logic [PAT_W-1:0]  below_mask;
    logic              more;

    morse_unit_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d    = state_q;
        cod_num_d  = cod_num_q;
        morse_d    = morse_q;
        disp_d     = disp_q;
        idx_d      = idx_q;
        cur_d      = cur_q;
        ponto_d    = ponto_q;
        traco_d    = traco_q;
        err_d      = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        sel        = highest_at_or_below(disp_q, idx_q);
        below_mask = (PAT_W'(1) << cur_q) - PAT_W'(1);
        more       = |(disp_q & below_mask);

        case (state_q)
            ST_IDLE: begin
                if (char_valid) begin
                    if (char_in > CHAR_W'(MAX_CHAR)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = ST_LOAD;
                        cod_num_d = char_in;
                    end
                end
            end
            ST_LOAD: state_d = ST_CAPT;
            ST_CAPT: begin
                morse_d = cod_morse;
                disp_d  = cod_display;
                idx_d   = 3'd4;
                if (cod_display == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                state_d  = ST_MARK;
                cur_d    = sel;
                tmr_load = 1'b1;
                tmr_val  = morse_q[sel] ? CNT_W'(DASH_CYC) : CNT_W'(DOT_CYC);
                ponto_d  = ~morse_q[sel];
                traco_d  = morse_q[sel];
            end
            ST_MARK: begin
                if (tmr_tc) begin
                    ponto_d = 1'b0;
                    traco_d = 1'b0;
                    if (more) begin
                        idx_d = cur_q - 3'd1;
                        // The SCAN cycle supplies the last cycle of the inter-element gap.
                        if (GAP_CYC > 1) begin
                            state_d  = ST_GAP;
                            tmr_load = 1'b1;
                            tmr_val  = CNT_W'(GAP_CYC - 1);
                        end else begin
                            state_d = ST_SCAN;
                        end
                    end else begin
                        state_d  = ST_CGAP;
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(CHAR_CYC);
                    end
                end
            end
            ST_GAP:  if (tmr_tc) state_d = ST_SCAN;
            ST_CGAP: if (tmr_tc) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        tone_d      = (state_d == ST_MARK);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        cod_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cod_num_q   <= '0;
            morse_q     <= '0;
            disp_q      <= '0;
            idx_q       <= '0;
            cur_q       <= '0;
            tone_q      <= 1'b0;
            ponto_q     <= 1'b0;
            traco_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cod_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cod_num_q   <= cod_num_d;
            morse_q     <= morse_d;
            disp_q      <= disp_d;
            idx_q       <= idx_d;
            cur_q       <= cur_d;
            tone_q      <= tone_d;
            ponto_q     <= ponto_d;
            traco_q     <= traco_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cod_ready_q <= cod_ready_d;
        end
    end

    assign char_accept = (state_q == ST_IDLE);
    assign cod_num     = cod_num_q;
    assign cod_ready   = cod_ready_q;
    assign tone_out    = tone_q;
    assign ponto_out   = ponto_q;
    assign traco_out   = traco_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// tb/tb_morse_tx_sequencer.sv - randomized self-checking bench with per-cycle waveform model
module tb_morse_tx_sequencer;

    localparam int U    = 2;
    localparam int DOT  = 1;
    localparam int DASH = 3;
    localparam int GAP  = 1;
    localparam int CHR  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] char_in;
    logic       char_valid;
    logic       char_accept;
    logic [5:0] cod_num;
    logic       cod_ready;
    logic [4:0] cod_morse;
    logic [4:0] cod_display;
    logic       tone_out, ponto_out, traco_out, busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [4:0] pat_d [64];
    logic [4:0] pat_m [64];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    morse_tx_sequencer #(
        .UNIT_CYCLES (U),
        .DOT_UNITS   (DOT),
        .DASH_UNITS  (DASH),
        .GAP_UNITS   (GAP),
        .CHAR_UNITS  (CHR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_accept (char_accept),
        .cod_num     (cod_num),
        .cod_ready   (cod_ready),
        .cod_morse   (cod_morse),
        .cod_display (cod_display),
        .tone_out    (tone_out),
        .ponto_out   (ponto_out),
        .traco_out   (traco_out),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // Codifier stand-in: pattern appears one cycle after the ready pulse.
    always @(posedge clk) begin
        if (cod_ready) begin
            cod_display <= pat_d[cod_num];
            cod_morse   <= pat_m[cod_num];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] w(input bit b, input bit t, input bit p, input bit tr,
                                     input bit d, input bit e, input bit r);
        return {~b, b, t, p, tr, d, e, r};
    endfunction

    function automatic logic [7:0] obs_word();
        return {char_accept, busy, tone_out, ponto_out, traco_out, done, err, cod_ready};
    endfunction

    // Expected per-cycle outputs from the transfer edge until back in idle.
    task automatic build_exp(input int c);
        int elems[$];
        exp_q.delete();
        if (c > 35) begin
            exp_q.push_back(w(0, 0, 0, 0, 0, 1, 0));
            exp_q.push_back(w(0, 0, 0, 0, 0, 0, 0));
            return;
        end
        exp_q.push_back(w(1, 0, 0, 0, 0, 0, 1));
        exp_q.push_back(w(1, 0, 0, 0, 0, 0, 0));
        if (pat_d[c] == 5'd0) begin
            exp_q.push_back(w(0, 0, 0, 0, 0, 1, 0));
            exp_q.push_back(w(0, 0, 0, 0, 0, 0, 0));
            return;
        end
        exp_q.push_back(w(1, 0, 0, 0, 0, 0, 0));
        for (int i = 4; i >= 0; i--) if (pat_d[c][i]) elems.push_back(i);
        foreach (elems[n]) begin
            bit dash;
            dash = pat_m[c][elems[n]];
            repeat ((dash ? DASH : DOT) * U) exp_q.push_back(w(1, 1, !dash, dash, 0, 0, 0));
            repeat ((n == elems.size() - 1 ? CHR : GAP) * U) exp_q.push_back(w(1, 0, 0, 0, 0, 0, 0));
        end
        exp_q.push_back(w(1, 0, 0, 0, 1, 0, 0));
        exp_q.push_back(w(0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic send_char(input int c, input int mid, input int abort_at);
        build_exp(c);
        @(negedge clk);
        chk("accept_pre", char_accept, 1);
        char_in    = 6'(c);
        char_valid = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            char_valid = (k == mid);
            if (k == mid) char_in = 6'($urandom_range(0, 35));
            chk($sformatf("c%0d_k%0d", c, k), obs_word(), exp_q[k]);
            if (exp_q[k][0]) chk($sformatf("cod_num_c%0d", c), cod_num, c);
            if (k == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("abort_idle", obs_word(), w(0, 0, 0, 0, 0, 0, 0));
                return;
            end
        end
        char_valid = 1'b0;
    endtask

    initial begin
        int c;
        int n;
        reset       = 1'b1;
        char_valid  = 1'b0;
        char_in     = '0;
        cod_morse   = '0;
        cod_display = '0;
        for (int i = 0; i < 64; i++) begin
            pat_d[i] = 5'($urandom);
            pat_m[i] = 5'($urandom);
        end
        pat_d[10] = 5'b11000; pat_m[10] = 5'b01000;
        pat_d[5]  = 5'b11111; pat_m[5]  = 5'b00000;
        pat_d[0]  = 5'b11111; pat_m[0]  = 5'b11111;
        pat_d[20] = 5'b00101; pat_m[20] = 5'b00001;
        pat_d[7]  = 5'b00000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", obs_word(), w(0, 0, 0, 0, 0, 0, 0));
        chk("reset_cod_num", cod_num, 0);
        reset = 1'b0;

        send_char(10, -1, -1);
        send_char(36, -1, -1);
        send_char(5, 10, -1);
        send_char(0, -1, 5);
        repeat (3) begin
            @(negedge clk);
            chk("post_abort_idle", obs_word(), w(0, 0, 0, 0, 0, 0, 0));
        end
        send_char(20, -1, -1);
        send_char(7, -1, -1);
        send_char(63, -1, -1);

        for (int t = 0; t < 20; t++) begin
            c = int'($urandom_range(0, 40));
            build_exp(c);
            n = exp_q.size();
            if (n > 8 && ($urandom_range(0, 1) == 1))
                send_char(c, int'($urandom_range(3, n - 3)), -1);
            else
                send_char(c, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
